// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and the write-request bundle used by the
// writeback path, the LU result buffer and the register-file write port.
package regfile_wb_arbiter_pkg;

   localparam int REG_COUNT  = 32;
   localparam int REG_ADDR_W = 5;
   localparam int WB_DATA_W  = 32;

   typedef struct packed {
      logic                  we;
      logic [REG_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0]  data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Busy bit per architectural register plus a count of in-flight LU ops.
// x0 is never marked busy, so lookups of x0 always return 0.
module reg_scoreboard
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_setEn,
   input  logic [REG_ADDR_W-1:0] i_setAddr,
   input  logic                  i_clrEn,
   input  logic [REG_ADDR_W-1:0] i_clrAddr,
   input  logic [REG_ADDR_W-1:0] i_lookAddrA,
   input  logic [REG_ADDR_W-1:0] i_lookAddrB,
   input  logic [REG_ADDR_W-1:0] i_lookAddrC,
   output logic                  o_busyA,
   output logic                  o_busyB,
   output logic                  o_busyC,
   output logic [CNT_W-1:0]      o_busyCount
);

   logic [REG_COUNT-1:0] r_busy;
   logic [CNT_W-1:0]     r_count;

   // Set wins over clear for the same bit, but decode's WAW check keeps
   // the issuing and draining registers distinct anyway.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy  <= '0;
         r_count <= '0;
      end else begin
         if (i_clrEn)
            r_busy[i_clrAddr] <= 1'b0;
         if (i_setEn && (i_setAddr != '0))
            r_busy[i_setAddr] <= 1'b1;
         case ({i_setEn, i_clrEn})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_busyA     = r_busy[i_lookAddrA];
   assign o_busyB     = r_busy[i_lookAddrB];
   assign o_busyC     = r_busy[i_lookAddrC];
   assign o_busyCount = r_count;

   a_noUnderflow : assert property (@(posedge clk) disable iff (!rst_n)
      i_clrEn |-> (r_count != '0));

   a_noOverflow : assert property (@(posedge clk) disable iff (!rst_n)
      (i_setEn && !i_clrEn) |-> (r_count < CNT_W'(MAX_OUTSTANDING)));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback (always
// first) and a one-entry LU result buffer; stalls decode on LU hazards.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int STARVE_LIMIT    = 8
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  ValidD,
   input  logic [REG_ADDR_W-1:0]                 Rs1D,
   input  logic [REG_ADDR_W-1:0]                 Rs2D,
   input  logic [REG_ADDR_W-1:0]                 RdD,
   input  logic                                  RegWriteD,
   input  logic                                  LongOpD,
   input  logic                                  RegWriteW,
   input  logic [REG_ADDR_W-1:0]                 RdW,
   input  logic [DATA_WIDTH-1:0]                 ResultW,
   input  logic                                  lu_valid,
   input  logic [REG_ADDR_W-1:0]                 lu_rd,
   input  logic [DATA_WIDTH-1:0]                 lu_data,
   output logic                                  lu_ready,
   output logic                                  WE3,
   output logic [REG_ADDR_W-1:0]                 A3,
   output logic [DATA_WIDTH-1:0]                 WD3,
   output logic                                  StallD,
   output logic                                  StarveStall,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  BusyCount
);

   localparam int CNT_W  = $clog2(MAX_OUTSTANDING+1);
   localparam int WAIT_W = $clog2(STARVE_LIMIT+1);

   wb_req_t          w_wbReq;
   wb_req_t          w_port;
   wb_req_t          r_buf;
   logic [WAIT_W-1:0] r_waitCnt;
   logic             w_drain;
   logic             w_load;
   logic             w_issue;
   logic             w_busyRs1;
   logic             w_busyRs2;
   logic             w_busyRd;
   logic             w_hazard;

   // The buffer's we bit doubles as its full flag.
   always_comb begin
      w_wbReq.we   = RegWriteW && (RdW != '0);
      w_wbReq.addr = RdW;
      w_wbReq.data = WB_DATA_W'(ResultW);

      w_port = '0;
      if (w_wbReq.we)
         w_port = w_wbReq;
      else if (r_buf.we)
         w_port = r_buf;
   end

   assign WE3      = w_port.we;
   assign A3       = w_port.addr;
   assign WD3      = w_port.data[DATA_WIDTH-1:0];
   assign lu_ready = !r_buf.we;
   assign w_load   = lu_valid && lu_ready;
   assign w_drain  = r_buf.we && !w_wbReq.we;

   assign StarveStall = (r_waitCnt >= WAIT_W'(STARVE_LIMIT));

   always_comb begin
      w_hazard = 1'b0;
      if (ValidD) begin
         if (w_busyRs1 || w_busyRs2)
            w_hazard = 1'b1;
         if (RegWriteD && w_busyRd)
            w_hazard = 1'b1;
         if (LongOpD && (BusyCount == CNT_W'(MAX_OUTSTANDING)))
            w_hazard = 1'b1;
      end
   end

   assign StallD  = w_hazard || StarveStall;
   assign w_issue = ValidD && LongOpD && RegWriteD && !StallD && (RdD != '0);

   // A load needs an empty buffer and a drain needs a full one, so the two
   // never coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf <= '0;
      end else if (w_load) begin
         r_buf.we   <= 1'b1;
         r_buf.addr <= lu_rd;
         r_buf.data <= WB_DATA_W'(lu_data);
      end else if (w_drain) begin
         r_buf.we <= 1'b0;
      end
   end

   // Counts cycles a buffered result loses the port to W; saturates at the
   // limit so StarveStall holds until the drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_waitCnt <= '0;
      else if (w_drain)
         r_waitCnt <= '0;
      else if (r_buf.we && w_wbReq.we && !StarveStall)
         r_waitCnt <= r_waitCnt + WAIT_W'(1);
   end

   reg_scoreboard #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W)
   ) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_setEn     (w_issue),
      .i_setAddr   (RdD),
      .i_clrEn     (w_drain),
      .i_clrAddr   (r_buf.addr),
      .i_lookAddrA (Rs1D),
      .i_lookAddrB (Rs2D),
      .i_lookAddrC (RdD),
      .o_busyA     (w_busyRs1),
      .o_busyB     (w_busyRs2),
      .o_busyC     (w_busyRd),
      .o_busyCount (BusyCount)
   );

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between the pipeline writeback stage (W) and a long-latency unit (LU, e.g. an iterative mul/div) that returns results out of order with the pipeline. A per-register scoreboard tracks destinations owned by in-flight LU ops. Decode is stalled on RAW/WAW hazards against those registers and when the outstanding-op limit is reached. Sits between decode/writeback and the register file's A3/WD3/WE3 inputs.

## Interface
- DATA_WIDTH, 32, register data width
- MAX_OUTSTANDING, 4, maximum in-flight LU ops
- STARVE_LIMIT, 8, cycles an LU result may wait before the pipeline is forced to drain

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ValidD  in  1  decode holds a real instruction
- Rs1D, Rs2D, RdD  in  5 each  decode register fields
- RegWriteD  in  1  decode instruction writes RdD
- LongOpD  in  1  decode instruction issues to the LU
- RegWriteW, RdW  in  1, 5  pipeline writeback request
- ResultW  in  DATA_WIDTH  pipeline writeback data
- lu_valid, lu_rd, lu_data  in  1, 5, DATA_WIDTH  LU result offer
- lu_ready  out  1  result buffer empty; the LU result is taken when lu_valid && lu_ready
- WE3, A3, WD3  out  1, 5, DATA_WIDTH  register file write port
- StallD  out  1  hold F/D and bubble E
- StarveStall  out  1  starvation drain request; also contributes to StallD
- BusyCount  out  $clog2(MAX_OUTSTANDING+1)  in-flight LU ops

## Operation
- Scoreboard: busy[31:1] registered; x0 is never busy.
- Issue is `ValidD && LongOpD && RegWriteD && !StallD && RdD!=0`. On issue:
  - set busy[RdD]
  - BusyCount += 1
- Result buffer: one entry {rd, data, full}. It loads on the lu_valid && lu_ready handshake.
- Write-port arbitration, with W having absolute priority (W is never stalled):
  - If RegWriteW && RdW!=0: WE3=1, A3=RdW, WD3=ResultW.
  - Else if the buffer is full: WE3=1, A3=buf.rd, WD3=buf.data. The buffer empties, busy[buf.rd] clears, and BusyCount -= 1 (all in the same edge).
  - Else WE3=0, with A3 and WD3 driven to 0.
- StallD is asserted when any of these holds:
  - ValidD && (busy[Rs1D] || busy[Rs2D]) (RAW; source reads of x0 ignored)
  - ValidD && RegWriteD && busy[RdD] (WAW)
  - ValidD && LongOpD && BusyCount==MAX_OUTSTANDING
  - StarveStall
- Starvation: a wait counter increments each cycle the buffer is full and W wins the port; it clears when the buffer drains.
  - StarveStall asserts when the counter reaches STARVE_LIMIT.
  - Bubbles reach W and the buffer drains within the pipe depth.
  - StarveStall deasserts on the cycle after the drain.
- lu_ready = !buf.full, registered. The buffer cannot load and drain in the same cycle.

## Timing
- Reset values (async assert):
  - busy=0, buffer empty, wait counter=0, BusyCount=0
  - WE3=0, A3=0, WD3=0, StallD=0, StarveStall=0, lu_ready=1
- StallD and the write port are combinational from registered state plus current inputs. The scoreboard is updated on the clock edge.
- Buffer drain latency is one cycle minimum: loaded at edge N, written to the register file at edge N+1 if W is idle.
- The busy bit clears at the drain edge. A dependent instruction stalled in D issues the cycle after the drain and reads the written value.
- Issue of a new LU op and a drain in the same cycle: BusyCount is unchanged (+1 and −1). Different registers are guaranteed by the WAW check.
- BusyCount never exceeds MAX_OUTSTANDING and never underflows. A drain with BusyCount==0 is a protocol error: flag it with an assertion.
- Reset mid-operation: buffer contents and pending busy bits are discarded. The LU is reset alongside.

## Structure
- Shared package: REG_COUNT=32 and REG_ADDR_W=5, plus a typedef struct for the write-request bundle {we, addr, data}, reused by decode and writeback.
- One sub-module, `reg_scoreboard`, holds the busy vector and BusyCount. Its inputs are set/clear address plus enables; its outputs are three busy lookups and BusyCount.
- Arbitration, the buffer and the starvation counter live in the top module.

## Test plan
- **LU issue, RAW hazard.** Issue LongOpD with RdD=5. Next instruction has Rs1D=5.
  - StallD=1 until the LU result (rd=5, data=0xDEAD) drains.
  - Then WE3=1, A3=5, WD3=0xDEAD, and StallD drops on the next cycle.
- **Port conflict.** LU result for rd=7 arrives while RegWriteW=1, RdW=3 for 3 cycles.
  - A3=3 for those cycles.
  - rd=7 is written on the first W-idle cycle.
  - lu_ready stays 0 until then.
- **Starvation.** W is busy continuously with a full buffer. StarveStall rises after 8 cycles, and the buffer drains once W idles.
- **Outstanding limit.** Issue 4 LU ops to x1–x4, then a 5th. StallD=1 until one drains, and BusyCount reads 4.
- **WAW, x0, reset.**
  - An LU op to x0 does not set busy.
  - A non-LU write to a busy rd stalls.
  - Assert rst_n low while the buffer is full: all outputs return to reset values immediately.
- **Same-cycle issue and drain.** BusyCount stays constant, and both busy bits update correctly.
